sdram_burst_writer: RTL

Parametrised SDRAM write-burst engine, successor to the fixed single-row write sequencer. It decodes a linear word address into bank, row and column, then issues ACTIVE, WRITE, BURST TERMINATE and PRECHARGE with configurable tRCD, tWR and tRP. It runs variable-length full-page bursts, truncates at the page boundary and reports how many words were actually written. It sits between the write-FIFO/arbiter and the SDRAM command mux, alongside the init and read engines.

---
 rtl/sdram_burst_writer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_writer.sv
`default_nettype none
// ============================================================================
// sdram_burst_writer : decodes {bank,row,col}, runs one page-truncated
//                      ACTIVE / WRITE / BST / PRECHARGE full-page write burst
// Rev 1.0
// ============================================================================
module sdram_burst_writer #(
   parameter int BA_W    = 2,
   parameter int ROW_W   = 13,
   parameter int COL_W   = 9,
   parameter int DATA_W  = 16,
   parameter int TRCD    = 2,
   parameter int TWR     = 2,
   parameter int TRP     = 2,
   parameter bit PRE_ALL = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          init_end_i,
   input  logic                          wr_en_i,
   input  logic [BA_W+ROW_W+COL_W-1:0]   wr_addr_i,
   input  logic [COL_W:0]                wr_burst_len_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   output logic                          wr_ack_o,
   output logic [3:0]                    wr_cmd_o,
   output logic [BA_W-1:0]               wr_ba_o,
   output logic [ROW_W-1:0]              wr_sdram_addr_o,
   output logic                          wr_sdram_en_o,
   output logic [DATA_W-1:0]             wr_sdram_data_o,
   output logic                          wr_busy_o,
   output logic                          wr_end_o,
   output logic [COL_W:0]                wr_len_done_o
);

   localparam int CW = COL_W + 1;
   localparam int AW = BA_W + ROW_W + COL_W;

   localparam logic [3:0] c_cmd_act = 4'b0011;
   localparam logic [3:0] c_cmd_wr  = 4'b0100;
   localparam logic [3:0] c_cmd_bst = 4'b0110;
   localparam logic [3:0] c_cmd_pre = 4'b0010;
   localparam logic [3:0] c_cmd_nop = 4'b0111;

   localparam logic [CW-1:0]    c_one       = CW'(1);
   localparam logic [CW-1:0]    c_page      = CW'(1) << COL_W;
   localparam logic [CW-1:0]    c_trcd_load = CW'(TRCD - 2);
   localparam logic [CW-1:0]    c_twr_load  = CW'(TWR - 2);
   localparam logic [CW-1:0]    c_trp_load  = CW'(TRP - 2);
   localparam logic [ROW_W-1:0] c_a10       = ROW_W'(1) << 10;
   localparam logic [ROW_W-1:0] c_pre_addr  = PRE_ALL ? c_a10 : '0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACTIVE = 3'd1,
      S_TRCD   = 3'd2,
      S_WRITE  = 3'd3,
      S_TWR    = 3'd4,
      S_PRE    = 3'd5,
      S_TRP    = 3'd6,
      S_END    = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       len_q, len_d;
   logic [BA_W-1:0]     bank_q, bank_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [BA_W-1:0]     ba_q, ba_d;
   logic [ROW_W-1:0]    addr_q, addr_d;
   logic                ack_q, ack_d;
   logic                en_q, en_d;
   logic                busy_q, busy_d;
   logic                end_q, end_d;
   logic [CW-1:0]       len_done_q, len_done_d;

   logic [CW-1:0]       w_room;
   logic [CW-1:0]       w_len_eff;
   logic                w_start;

   // Words left in the page from the start column; clips oversize requests too.
   assign w_room    = c_page - CW'(wr_addr_i[COL_W-1:0]);
   assign w_len_eff = (wr_burst_len_i > w_room) ? w_room : wr_burst_len_i;
   assign w_start   = wr_en_i & init_end_i & (wr_burst_len_i != '0);

   // cnt_q holds the number of cycles left in the current state after this one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
               bank_d  = wr_addr_i[AW-1 -: BA_W];
               row_d   = wr_addr_i[COL_W +: ROW_W];
               col_d   = wr_addr_i[COL_W-1:0];
               len_d   = w_len_eff;
            end
         end
         S_ACTIVE: begin
            if (TRCD == 1) begin
               state_d = S_WRITE;
               cnt_d   = len_q - c_one;
            end else begin
               state_d = S_TRCD;
               cnt_d   = c_trcd_load;
            end
         end
         S_TRCD: begin
            if (cnt_q == '0) begin
               state_d = S_WRITE;
               cnt_d   = len_q - c_one;
            end else begin
               cnt_d = cnt_q - c_one;
            end
         end
         S_WRITE: begin
            if (cnt_q == '0) begin
               state_d = S_TWR;
               cnt_d   = c_twr_load;
            end else begin
               cnt_d = cnt_q - c_one;
            end
         end
         S_TWR: begin
            if (cnt_q == '0) begin
               state_d = S_PRE;
            end else begin
               cnt_d = cnt_q - c_one;
            end
         end
         S_PRE: begin
            if (TRP == 1) begin
               state_d = S_END;
            end else begin
               state_d = S_TRP;
               cnt_d   = c_trp_load;
            end
         end
         S_TRP: begin
            if (cnt_q == '0) begin
               state_d = S_END;
            end else begin
               cnt_d = cnt_q - c_one;
            end
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      cmd_d      = c_cmd_nop;
      ba_d       = '1;
      addr_d     = '1;
      ack_d      = 1'b0;
      en_d       = 1'b0;
      busy_d     = (state_d != S_IDLE);
      end_d      = (state_d == S_END);
      len_done_d = end_d ? len_d : '0;
      case (state_d)
         S_ACTIVE: begin
            cmd_d  = c_cmd_act;
            ba_d   = bank_d;
            addr_d = row_d;
         end
         S_WRITE: begin
            en_d  = 1'b1;
            ack_d = (cnt_d != '0);
            if (state_q != S_WRITE) begin
               cmd_d  = c_cmd_wr;
               ba_d   = bank_d;
               addr_d = ROW_W'(col_d) & ~c_a10;
            end
         end
         S_TWR: begin
            if (state_q == S_WRITE) begin
               cmd_d  = c_cmd_bst;
               ba_d   = bank_d;
               addr_d = '0;
            end
         end
         S_PRE: begin
            cmd_d  = c_cmd_pre;
            ba_d   = bank_d;
            addr_d = c_pre_addr;
         end
         default: ;
      endcase
      // First request runs one cycle ahead of the first data beat.
      if ((state_d == S_TRCD && cnt_d == '0) || (state_d == S_ACTIVE && TRCD == 1)) begin
         ack_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         bank_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         cmd_q      <= c_cmd_nop;
         ba_q       <= '1;
         addr_q     <= '1;
         ack_q      <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         end_q      <= 1'b0;
         len_done_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         bank_q     <= bank_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cmd_q      <= cmd_d;
         ba_q       <= ba_d;
         addr_q     <= addr_d;
         ack_q      <= ack_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         end_q      <= end_d;
         len_done_q <= len_done_d;
      end
   end

   assign wr_cmd_o        = cmd_q;
   assign wr_ba_o         = ba_q;
   assign wr_sdram_addr_o = addr_q;
   assign wr_ack_o        = ack_q;
   assign wr_sdram_en_o   = en_q;
   assign wr_busy_o       = busy_q;
   assign wr_end_o        = end_q;
   assign wr_len_done_o   = len_done_q;
   assign wr_sdram_data_o = en_q ? wr_data_i : '0;

endmodule
`default_nettype wire
